core_output_collector: RTL and testbench
========================================

// Module: core_output_collector
// PURPOSE
// - Downstream of the multicore array: gathers per-core result strobes (out_en/io_out) from NCORES cores.
// - Serialises results into one ordered valid/ready stream for the file-writer/host side.
// - One holding register per core, round-robin arbiter, FIFO_DEPTH-entry output FIFO.
// - Sticky overflow flag for a core result lost while that core's holding register is occupied.
// PARAMETERS
// - NCORES      54  number of core result ports (1..64)
// - DW          31  result width, signed two's complement
// - FIFO_DEPTH  16  output FIFO entries; power of two, >=2
// - IW           6  core index width; clog2(NCORES), minimum 1
// PORTS
// - clk        in   1          system clock, all logic on posedge
// - rst_n      in   1          asynchronous active-low reset
// - core_data  in   NCORES*DW  core i result on bits [i*DW +: DW]
// - core_en    in   NCORES     core i result strobe; 1-cycle pulse per result
// - out_data   out  DW         head-of-FIFO result; valid only when out_valid=1
// - out_core   out  IW         index of core that produced out_data (see CONFIGURATION)
// - out_valid  out  1          FIFO not empty
// - out_ready  in   1          consumer accepts; pop when out_valid & out_ready
// - fifo_cnt   out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
// - ovf        out  NCORES     sticky per-core overflow flags
// - ovf_clr    in   1          clears all ovf bits
// BEHAVIOUR
// - Reset values: out_valid=0, out_data=0, out_core=0, fifo_cnt=0, ovf=0; holding regs empty; rr_ptr=NCORES-1.
// - Capture, per core i on each edge: if core_en[i], hold_data[i]<=core_data[i*DW+:DW], hold_full[i]<=1.
// - Strobe while hold_full[i]=1 and not granted this cycle: new sample dropped, held sample kept, ovf[i]<=1.
// - Strobe on a cycle where core i is granted: granted sample goes to FIFO, new sample captured, no overflow.
// - Arbiter: combinational; grants at most one core per cycle.
//   - Grant only when fifo_cnt<FIFO_DEPTH, sampled before this cycle's pop.
//   - Search order starts at rr_ptr+1 and wraps NCORES-1 -> 0.
//   - Grant g pushes {g, hold_data[g]}, clears hold_full[g], sets rr_ptr<=g.
//   - No request: rr_ptr unchanged.
// - Latency: strobe sampled at edge E0, FIFO write at E1, out_valid=1 after E1 (2 edges) when uncontended.
// - FIFO: show-ahead; out_data/out_core driven from the head entry. Entries are not reordered.
//   - Push and pop in the same cycle: cnt unchanged. Pop with cnt=0 is ignored.
//   - Full FIFO: no grants that cycle even if a pop occurs; holding regs absorb the backpressure.
//   - FIFO read/write pointers wrap modulo FIFO_DEPTH.
// - Throughput: 1 result/cycle sustained. Core i waits at most NCORES-1 grants once the FIFO has space.
// - ovf: set-dominant; a set and ovf_clr in the same cycle leaves the bit at 1.
// - Reset mid-operation: immediately discards FIFO contents and holding registers; no partial output.
// - Width: data passes through bit-exact; no sign extension or truncation.
// CONFIGURATION
// - Macro COLLECT_TAG_EN.
//   - Defined: FIFO entries are IW+DW bits; out_core = producing core index.
//   - Undefined: FIFO entries are DW bits; out_core tied to 0; tag storage not built.
// TESTING
// - Single strobe: core 5 pulses 1234 with out_ready=1 -> out_valid 2 edges later, data 1234, out_core=5 (TAG_EN), cnt back to 0.
// - Simultaneous: cores 0, 1 and 53 strobe -5, 7, 99 in one cycle -> output order 0, 1, 53 after reset; next burst starts after 53.
// - Backpressure: out_ready=0, 20 strobes spread over distinct cores -> cnt saturates at 16, remaining 4 stay in holding regs.
//   - Then out_ready=1 -> all 20 emerge, none lost, ovf=0.
// - Overflow: out_ready=0, FIFO full, core 3 strobes 10 then 11 -> ovf[3]=1; after drain, only 10 appears from core 3.
//   - ovf_clr -> ovf=0.
// - Grant+strobe: core 7 held and granted in the same cycle it strobes 42 -> both values delivered in order, ovf[7]=0.
// - Reset mid-stream: rst_n low with cnt=9 -> out_valid=0, cnt=0 asynchronously; post-reset strobe delivered normally.

Source files
------------

// File: rtl/core_output_collector.sv
// Per-core result collector: holding registers, round-robin arbiter and show-ahead output FIFO.
// Define COLLECT_TAG_EN to carry the producing core index alongside each result.
module core_output_collector #(
   parameter int unsigned NCORES     = 54,
   parameter int unsigned DW         = 31,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned IW         = 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NCORES*DW-1:0]         core_data,
   input  logic [NCORES-1:0]            core_en,
   output logic [DW-1:0]                out_data,
   output logic [IW-1:0]                out_core,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt,
   output logic [NCORES-1:0]            ovf,
   input  logic                         ovf_clr
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
`ifdef COLLECT_TAG_EN
   localparam int unsigned EW = IW + DW;
`else
   localparam int unsigned EW = DW;
`endif

   logic [DW-1:0]     r_hold_data [NCORES];
   logic [NCORES-1:0] r_hold_full;
   logic [NCORES-1:0] r_ovf;
   logic [IW-1:0]     r_rr_ptr;
   logic [EW-1:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_cnt;
   logic              r_valid;
   logic [EW-1:0]     r_head;

   logic              w_space;
   logic              w_grant;
   logic              w_pop;
   logic [IW-1:0]     w_grant_idx;
   logic [NCORES-1:0] w_grant_vec;
   logic [NCORES-1:0] w_ovf_set;
   logic [EW-1:0]     w_push_word;
   logic [AW-1:0]     w_rd_next;
   logic [CW-1:0]     w_cnt_next;

   assign w_space    = (r_cnt < CW'(FIFO_DEPTH));
   assign w_pop      = r_valid & out_ready;
   assign w_rd_next  = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
   assign w_cnt_next = r_cnt + CW'(w_grant) - CW'(w_pop);
   assign w_ovf_set  = core_en & r_hold_full & ~w_grant_vec;

   // Round-robin search starting just after the last granted core.
   always_comb begin
      int unsigned idx;
      idx         = 0;
      w_grant     = 1'b0;
      w_grant_idx = r_rr_ptr;
      w_grant_vec = '0;
      for (int unsigned k = 1; k <= NCORES; k++) begin
         idx = 32'(r_rr_ptr) + k;
         if (idx >= NCORES) idx = idx - NCORES;
         if (w_space && !w_grant && r_hold_full[IW'(idx)]) begin
            w_grant                  = 1'b1;
            w_grant_idx              = IW'(idx);
            w_grant_vec[IW'(idx)]    = 1'b1;
         end
      end
   end

`ifdef COLLECT_TAG_EN
   assign w_push_word = {w_grant_idx, r_hold_data[w_grant_idx]};
   assign out_core    = r_head[EW-1:DW];
`else
   assign w_push_word = r_hold_data[w_grant_idx];
   assign out_core    = '0;
`endif
   assign out_data  = r_head[DW-1:0];
   assign out_valid = r_valid;
   assign fifo_cnt  = r_cnt;
   assign ovf       = r_ovf;

   // Holding registers: a granted slot may capture a new strobe in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_full <= '0;
         r_ovf       <= '0;
         for (int i = 0; i < int'(NCORES); i++) r_hold_data[i] <= '0;
      end else begin
         r_ovf <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
         for (int i = 0; i < int'(NCORES); i++) begin
            if (core_en[i] && (!r_hold_full[i] || w_grant_vec[i])) begin
               r_hold_data[i] <= core_data[i*DW +: DW];
               r_hold_full[i] <= 1'b1;
            end else if (w_grant_vec[i]) begin
               r_hold_full[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_grant) r_mem[r_wr_ptr] <= w_push_word;
   end

   // Head register is preloaded from the next read slot, bypassing a write to that slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= IW'(NCORES - 1);
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_valid  <= 1'b0;
         r_head   <= '0;
      end else begin
         if (w_grant) begin
            r_rr_ptr <= w_grant_idx;
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         r_rd_ptr <= w_rd_next;
         r_cnt    <= w_cnt_next;
         r_valid  <= (w_cnt_next != '0);
         r_head   <= (w_grant && (r_wr_ptr == w_rd_next)) ? w_push_word : r_mem[w_rd_next];
      end
   end

endmodule

// File: tb/tb_core_output_collector.sv
// Randomized and directed bench for core_output_collector against a queue-based reference model.
module tb_core_output_collector;

   localparam int unsigned NCORES     = 54;
   localparam int unsigned DW         = 31;
   localparam int unsigned FIFO_DEPTH = 16;
   localparam int unsigned IW         = 6;
   localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;

   logic                 clk;
   logic                 rst_n;
   logic [NCORES*DW-1:0] core_data;
   logic [NCORES-1:0]    core_en;
   logic [DW-1:0]        out_data;
   logic [IW-1:0]        out_core;
   logic                 out_valid;
   logic                 out_ready;
   logic [CW-1:0]        fifo_cnt;
   logic [NCORES-1:0]    ovf;
   logic                 ovf_clr;

   core_output_collector #(
      .NCORES(NCORES), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH), .IW(IW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .core_data(core_data), .core_en(core_en),
      .out_data(out_data), .out_core(out_core), .out_valid(out_valid),
      .out_ready(out_ready), .fifo_cnt(fifo_cnt), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            core;
      logic [DW-1:0] data;
   } ent_t;

   int            n_checks = 0;
   int            n_errors = 0;
   ent_t          m_q[$];
   ent_t          tr[$];
   bit            m_full[NCORES];
   logic [DW-1:0] m_hold[NCORES];
   logic [63:0]   m_ovf;
   int            m_rr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_core(input int c);
`ifdef COLLECT_TAG_EN
      return 64'(c);
`else
      return (c < 0) ? 64'd0 : 64'd0;
`endif
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_ovf = '0;
      m_rr  = NCORES - 1;
      for (int c = 0; c < int'(NCORES); c++) begin
         m_full[c] = 1'b0;
         m_hold[c] = '0;
      end
   endtask

   // One clock edge of the reference behaviour, using the inputs sampled at that edge.
   task automatic model_step();
      int  g;
      bit  space;
      bit  pop;
      space = (m_q.size() < int'(FIFO_DEPTH));
      pop   = (m_q.size() != 0) && out_ready;
      g     = -1;
      if (space) begin
         for (int k = 1; k <= int'(NCORES); k++) begin
            int c;
            c = (m_rr + k) % int'(NCORES);
            if (g < 0 && m_full[c]) g = c;
         end
      end
      if (pop) void'(m_q.pop_front());
      if (g >= 0) begin
         m_q.push_back('{g, m_hold[g]});
         m_full[g] = 1'b0;
         m_rr      = g;
      end
      if (ovf_clr) m_ovf = '0;
      for (int c = 0; c < int'(NCORES); c++) begin
         if (core_en[c]) begin
            if (m_full[c]) m_ovf[c] = 1'b1;
            else begin
               m_hold[c] = core_data[c*DW +: DW];
               m_full[c] = 1'b1;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("cnt", 64'(fifo_cnt), 64'(m_q.size()));
      check("valid", 64'(out_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check("data", 64'(out_data), 64'(m_q[0].data));
         check("core", 64'(out_core), exp_core(m_q[0].core));
      end
      check("ovf", 64'(ovf), m_ovf);
   endtask

   task automatic strobe(input int c, input logic [DW-1:0] d);
      core_en[c]            = 1'b1;
      core_data[c*DW +: DW] = d;
   endtask

   // Record the pop at the coming edge, advance one edge, compare, and clear pulses.
   task automatic cycle();
      if (out_valid && out_ready) tr.push_back('{int'(out_core), out_data});
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      core_en = '0;
      ovf_clr = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   int            cnt10, cnt11, cnt77;
   logic [DW-1:0] v_neg5;

   initial begin
      rst_n     = 1'b0;
      core_data = '0;
      core_en   = '0;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
      v_neg5    = DW'(-5);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data", 64'(out_data), 64'd0);
      check("rst_core", 64'(out_core), 64'd0);
      check("rst_cnt", 64'(fifo_cnt), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      rst_n = 1'b1;

      // Single strobe latency
      out_ready = 1'b1;
      strobe(5, DW'(1234));
      cycle();
      check("single_lat_e0", 64'(out_valid), 64'd0);
      cycle();
      check("single_valid", 64'(out_valid), 64'd1);
      check("single_data", 64'(out_data), 64'd1234);
      check("single_core", 64'(out_core), exp_core(5));
      cycle();
      check("single_cnt0", 64'(fifo_cnt), 64'd0);
      run(2);

      // Simultaneous strobes: rr pointer is at 5 now, so reset first to start the search at 0
      rst_n = 1'b0;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tr.delete();
      strobe(0, v_neg5);
      strobe(1, DW'(7));
      strobe(53, DW'(99));
      cycle();
      run(6);
      check("simul_n", 64'(tr.size()), 64'd3);
      if (tr.size() == 3) begin
         check("simul_d0", 64'(tr[0].data), 64'(v_neg5));
         check("simul_d1", 64'(tr[1].data), 64'd7);
         check("simul_d2", 64'(tr[2].data), 64'd99);
         check("simul_c2", 64'(tr[2].core), exp_core(53));
      end
      tr.delete();
      strobe(53, DW'(300));
      strobe(2, DW'(200));
      cycle();
      run(5);
      check("wrap_n", 64'(tr.size()), 64'd2);
      if (tr.size() == 2) begin
         check("wrap_d0", 64'(tr[0].data), 64'd200);
         check("wrap_d1", 64'(tr[1].data), 64'd300);
      end

      // Backpressure: 20 distinct cores, FIFO saturates at its depth
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         strobe(10 + i, DW'(1000 + i));
         cycle();
      end
      run(3);
      check("bp_full", 64'(fifo_cnt), 64'(FIFO_DEPTH));
      tr.delete();
      out_ready = 1'b1;
      run(30);
      check("bp_n", 64'(tr.size()), 64'd20);
      for (int i = 0; i < tr.size() && i < 20; i++) check("bp_order", 64'(tr[i].data), 64'(1000 + i));
      check("bp_ovf", 64'(ovf), 64'd0);

      // Overflow on a held core while the FIFO is full
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         strobe(20 + i, DW'(2000 + i));
         cycle();
      end
      run(2);
      strobe(3, DW'(10));
      cycle();
      strobe(3, DW'(11));
      cycle();
      check("ovf_set3", 64'(ovf[3]), 64'd1);
      tr.delete();
      out_ready = 1'b1;
      run(30);
      cnt10 = 0;
      cnt11 = 0;
      foreach (tr[i]) begin
         if (tr[i].data == DW'(10)) cnt10++;
         if (tr[i].data == DW'(11)) cnt11++;
      end
      check("ovf_kept10", 64'(cnt10), 64'd1);
      check("ovf_drop11", 64'(cnt11), 64'd0);
      ovf_clr = 1'b1;
      cycle();
      check("ovf_clr", 64'(ovf), 64'd0);

      // Grant and strobe on the same core in the same cycle
      tr.delete();
      strobe(7, DW'(41));
      cycle();
      strobe(7, DW'(42));
      cycle();
      run(5);
      check("gs_n", 64'(tr.size()), 64'd2);
      if (tr.size() == 2) begin
         check("gs_d0", 64'(tr[0].data), 64'd41);
         check("gs_d1", 64'(tr[1].data), 64'd42);
         check("gs_c1", 64'(tr[1].core), exp_core(7));
      end
      check("gs_ovf7", 64'(ovf[7]), 64'd0);

      // Asynchronous reset in the middle of a stream
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         strobe(40 + i, DW'(3000 + i));
         cycle();
      end
      run(3);
      check("mid_cnt9", 64'(fifo_cnt), 64'd9);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_cnt", 64'(fifo_cnt), 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tr.delete();
      out_ready = 1'b1;
      strobe(12, DW'(77));
      cycle();
      run(4);
      cnt77 = 0;
      foreach (tr[i]) if (tr[i].data == DW'(77)) cnt77++;
      check("post_rst_n", 64'(tr.size()), 64'd1);
      check("post_rst_77", 64'(cnt77), 64'd1);

      // Randomized traffic with stall windows and occasional clears
      for (int n = 0; n < 2500; n++) begin
         for (int c = 0; c < int'(NCORES); c++)
            if ($urandom_range(0, 39) == 0) strobe(c, DW'($urandom));
         out_ready = (n % 600 > 450) ? 1'b0 : ($urandom_range(0, 3) != 0);
         ovf_clr   = ($urandom_range(0, 49) == 0);
         cycle();
      end
      out_ready = 1'b1;
      run(80);
      check("final_empty", 64'(fifo_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
